// File: rtl/mem_responder.sv
// Memory-side responder for a multicycle CPU: unified word store with a fixed
// number of wait states, a one-cycle MemReady pulse and MemErr reporting.
module mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              MemReady,
    output logic              MemBusy,
    output logic              MemErr
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_responder: WAIT_CYCLES must be in 0..15");
        end
        if (DEPTH < 2 || longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
            $error("mem_responder: DEPTH must be in 2..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q, oor_q;
    logic              accept, both, commit, oor_in;
    logic [IDX_W-1:0]  eff_idx;
    logic [DATA_W-1:0] eff_wdata;
    logic              eff_write, eff_oor;
    logic [DATA_W-1:0] mem [DEPTH];

    // When the address space is fully implemented nothing can be out of range.
    generate
        if (longint'(DEPTH) >= (64'd1 << ADDR_W)) begin : g_full
            assign oor_in = 1'b0;
        end else begin : g_part
            assign oor_in = (Addr >= ADDR_W'(DEPTH));
        end
    endgenerate

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        both       = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemRead ^ MemWrite) begin
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end else if (MemRead && MemWrite) begin
                    both = 1'b1;
                end
            end
            S_WAIT:  if (cnt == 4'd1) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign commit = (next_state == S_DONE) && (state != S_DONE);

    // With zero wait states the commit edge is the acceptance edge, so the
    // live inputs are used instead of the (not yet loaded) latches.
    assign eff_idx   = (state == S_IDLE) ? Addr[IDX_W-1:0] : idx_q;
    assign eff_wdata = (state == S_IDLE) ? WData           : wdata_q;
    assign eff_write = (state == S_IDLE) ? MemWrite        : write_q;
    assign eff_oor   = (state == S_IDLE) ? oor_in          : oor_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            RData   <= '0;
            MemErr  <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state  <= next_state;
            MemErr <= both || (commit && eff_oor);
            if (accept) begin
                cnt     <= 4'(WAIT_CYCLES);
                idx_q   <= Addr[IDX_W-1:0];
                wdata_q <= WData;
                write_q <= MemWrite;
                oor_q   <= oor_in;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !eff_write)
                RData <= eff_oor ? '0 : mem[eff_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && commit && eff_write && !eff_oor)
            mem[eff_idx] <= eff_wdata;
    end

    assign MemReady = (state == S_DONE);
    assign MemBusy  = (state != S_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and a
// partial address map, one with zero wait states and a full map.
module tb_mem_responder;
    logic       clock = 1'b0;
    logic       reset;
    logic       rd_a, wr_a, ready_a, busy_a, err_a;
    logic [7:0] addr_a, wdata_a, rdata_a;
    logic       rd_b, wr_b, ready_b, busy_b, err_b;
    logic [7:0] addr_b, wdata_b, rdata_b;
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) dut_a (
        .clock(clock), .reset(reset), .MemRead(rd_a), .MemWrite(wr_a), .Addr(addr_a),
        .WData(wdata_a), .RData(rdata_a), .MemReady(ready_a), .MemBusy(busy_a), .MemErr(err_a));

    mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .MemRead(rd_b), .MemWrite(wr_b), .Addr(addr_b),
        .WData(wdata_b), .RData(rdata_b), .MemReady(ready_b), .MemBusy(busy_b), .MemErr(err_b));

    // Drives one request starting just after an edge; returns latency from the
    // accepting edge to the MemReady cycle (-1 on timeout), then steps to IDLE.
    task automatic access(input bit sel_b, input logic r, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output int lat, output logic [7:0] q,
                          output logic e, output logic b1);
        logic rdy;
        if (sel_b) begin rd_b = r; wr_b = w; addr_b = a; wdata_b = d; end
        else       begin rd_a = r; wr_a = w; addr_a = a; wdata_a = d; end
        @(posedge clock); #1;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        lat = 1;
        b1  = sel_b ? busy_b : busy_a;
        rdy = sel_b ? ready_b : ready_a;
        while (!rdy && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            rdy = sel_b ? ready_b : ready_a;
        end
        q = sel_b ? rdata_b : rdata_a;
        e = sel_b ? err_b : err_a;
        if (!rdy) lat = -1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rd_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0;
        rd_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0;
        repeat (2) @(posedge clock);
        #1;
        total++; if ({rdata_a, ready_a, busy_a, err_a} !== 11'd0) begin bad++;
            $display("FAIL reset_a: got rdata=%h rdy=%b busy=%b err=%b want 0", rdata_a, ready_a, busy_a, err_a); end
        total++; if ({rdata_b, ready_b, busy_b, err_b} !== 11'd0) begin bad++;
            $display("FAIL reset_b: got rdata=%h rdy=%b busy=%b err=%b want 0", rdata_b, ready_b, busy_b, err_b); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read;
        int lat; logic [7:0] q; logic e, b1;
        access(0, 0, 1, 8'h10, 8'hA5, lat, q, e, b1);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", b1); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", e); end
        total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL wr_rdata_hold: got %h want 00", rdata_a); end
        access(0, 1, 0, 8'h10, 8'h00, lat, q, e, b1);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", q); end
    endtask

    task automatic test_both_strobes;
        int lat; logic [7:0] q; logic e, b1; bit seen;
        rd_a = 1; wr_a = 1; addr_a = 8'h10; wdata_a = 8'h00;
        @(posedge clock); #1;
        rd_a = 0; wr_a = 0;
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL both_err: got %b want 1", err_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL both_busy: got %b want 0", busy_a); end
        seen = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (err_a || ready_a) seen = 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL both_after: got err/ready=1 want 0"); end
        access(0, 1, 0, 8'h10, 8'h00, lat, q, e, b1);
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL both_nochange: got %h want a5", q); end
    endtask

    task automatic test_out_of_range;
        int lat; logic [7:0] q; logic e, b1;
        access(0, 0, 1, 8'h00, 8'h5C, lat, q, e, b1);
        access(0, 1, 0, 8'h80, 8'h00, lat, q, e, b1);
        total++; if (lat !== 3) begin bad++; $display("FAIL oor_latency: got %0d want 3", lat); end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL oor_rdata: got %h want 00", q); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_rd_err: got %b want 1", e); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL oor_err_pulse: got %b want 0", err_a); end
        access(0, 0, 1, 8'h80, 8'h33, lat, q, e, b1);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", e); end
        access(0, 1, 0, 8'h00, 8'h00, lat, q, e, b1);
        total++; if (q !== 8'h5C) begin bad++; $display("FAIL oor_wr_discard: got %h want 5c", q); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL inrange_err: got %b want 0", e); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [7:0] q; logic e, b1;
        access(1, 0, 1, 8'h01, 8'h3C, lat, q, e, b1);
        total++; if (lat !== 1) begin bad++; $display("FAIL zw_wr_latency: got %0d want 1", lat); end
        access(1, 0, 1, 8'h02, 8'h4D, lat, q, e, b1);
        rd_b = 1; addr_b = 8'h01;
        @(posedge clock); #1;
        total++; if ({ready_b, rdata_b} !== {1'b1, 8'h3C}) begin bad++;
            $display("FAIL b2b_first: got rdy=%b rdata=%h want 1/3c", ready_b, rdata_b); end
        addr_b = 8'h02;
        @(posedge clock); #1;
        total++; if ({ready_b, rdata_b} !== {1'b0, 8'h3C}) begin bad++;
            $display("FAIL b2b_gap: got rdy=%b rdata=%h want 0/3c", ready_b, rdata_b); end
        @(posedge clock); #1;
        total++; if ({ready_b, rdata_b} !== {1'b1, 8'h4D}) begin bad++;
            $display("FAIL b2b_second: got rdy=%b rdata=%h want 1/4d", ready_b, rdata_b); end
        rd_b = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_abort;
        int lat; logic [7:0] q; logic e, b1; bit seen;
        access(0, 0, 1, 8'h20, 8'h11, lat, q, e, b1);
        wr_a = 1; addr_a = 8'h20; wdata_a = 8'h77;
        @(posedge clock); #1;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", busy_a); end
        reset = 1; wr_a = 0;
        #1;
        total++; if ({busy_a, rdata_a} !== 9'd0) begin bad++;
            $display("FAIL abort_async: got busy=%b rdata=%h want 0/00", busy_a, rdata_a); end
        seen = 0;
        repeat (2) begin @(posedge clock); #1; if (ready_a) seen = 1; end
        reset = 0;
        repeat (4) begin @(posedge clock); #1; if (ready_a) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_ready: got pulse want none"); end
        access(0, 1, 0, 8'h20, 8'h00, lat, q, e, b1);
        total++; if (q !== 8'h11) begin bad++; $display("FAIL abort_nowrite: got %h want 11", q); end
    endtask

    task automatic test_strobe_during_wait;
        int lat; logic [7:0] q; logic e, b1;
        access(0, 0, 1, 8'h40, 8'h44, lat, q, e, b1);
        access(0, 0, 1, 8'h50, 8'h55, lat, q, e, b1);
        wr_a = 1; addr_a = 8'h30; wdata_a = 8'h66;
        @(posedge clock); #1;
        wr_a = 0; rd_a = 1; addr_a = 8'h40; wdata_a = 8'hEE;
        @(posedge clock); #1;
        rd_a = 0; wr_a = 1; addr_a = 8'h50;
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL wait_early_ready: got 1 want 0"); end
        @(posedge clock); #1;
        wr_a = 0;
        total++; if ({ready_a, err_a} !== 2'b10) begin bad++;
            $display("FAIL wait_done: got rdy=%b err=%b want 1/0", ready_a, err_a); end
        @(posedge clock); #1;
        access(0, 1, 0, 8'h30, 8'h00, lat, q, e, b1);
        total++; if (q !== 8'h66) begin bad++; $display("FAIL wait_latched: got %h want 66", q); end
        access(0, 1, 0, 8'h40, 8'h00, lat, q, e, b1);
        total++; if (q !== 8'h44) begin bad++; $display("FAIL wait_untouched40: got %h want 44", q); end
        access(0, 1, 0, 8'h50, 8'h00, lat, q, e, b1);
        total++; if (q !== 8'h55) begin bad++; $display("FAIL wait_untouched50: got %h want 55", q); end
        // Read whose address changes mid-wait must use the accepted address.
        rd_a = 1; addr_a = 8'h10;
        @(posedge clock); #1;
        rd_a = 0; addr_a = 8'h30;
        repeat (2) @(posedge clock);
        #1;
        total++; if ({ready_a, rdata_a} !== {1'b1, 8'hA5}) begin bad++;
            $display("FAIL wait_rd_addr: got rdy=%b rdata=%h want 1/a5", ready_a, rdata_a); end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_both_strobes;
        test_out_of_range;
        test_back_to_back;
        test_reset_abort;
        test_strobe_during_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
